// File: rtl/light_pkg.sv
// Shared constants for the rotary-encoder front end: FSM encoding,
// debounce counter width and the idle contact level.
package light_pkg;

   localparam int DEBOUNCE_CNT_W = 16;

   // Both contacts are pulled up, so a resting encoder reads {a,b} = 11.
   localparam logic [1:0] IDLE_LEVEL = 2'b11;

   localparam logic [2:0] ST_IDLE_ENC = 3'd0;
   localparam logic [2:0] ST_R1_ENC   = 3'd1;
   localparam logic [2:0] ST_R2_ENC   = 3'd2;
   localparam logic [2:0] ST_R3_ENC   = 3'd3;
   localparam logic [2:0] ST_L1_ENC   = 3'd4;
   localparam logic [2:0] ST_L2_ENC   = 3'd5;
   localparam logic [2:0] ST_L3_ENC   = 3'd6;
   localparam logic [2:0] ST_WAIT_ENC = 3'd7;

   typedef enum logic [2:0] {
      S_IDLE = ST_IDLE_ENC,
      S_R1   = ST_R1_ENC,
      S_R2   = ST_R2_ENC,
      S_R3   = ST_R3_ENC,
      S_L1   = ST_L1_ENC,
      S_L2   = ST_L2_ENC,
      S_L3   = ST_L3_ENC,
      S_WAIT = ST_WAIT_ENC
   } state_t;

endpackage

// File: rtl/quadrature_decoder_if.sv
// Encoder pins in, debounced levels and detent strobes out.
interface quadrature_decoder_if;

   logic a_i;
   logic b_i;
   logic a_db_o;
   logic b_db_o;
   logic inc_o;
   logic dec_o;
   logic err_o;

   modport master (
      output a_i,
      output b_i,
      input  a_db_o,
      input  b_db_o,
      input  inc_o,
      input  dec_o,
      input  err_o
   );

   modport slave (
      input  a_i,
      input  b_i,
      output a_db_o,
      output b_db_o,
      output inc_o,
      output dec_o,
      output err_o
   );

endinterface

// File: rtl/quadrature_decoder_contact.sv
// One encoder contact: two-flop synchroniser followed by a stability counter
// that only lets a new level through after DEBOUNCE_CYCLES steady cycles.
module contact_debouncer
   import light_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 100
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic raw,
   output logic db
);

   localparam logic [DEBOUNCE_CNT_W-1:0] LAST_CNT = DEBOUNCE_CNT_W'(DEBOUNCE_CYCLES - 1);

   logic                      sync1_reg;
   logic                      sync2_reg;
   logic [DEBOUNCE_CNT_W-1:0] cnt_reg;
   logic                      db_reg;

   // Synchroniser resets high to match the idle (pulled-up) contact level.
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         sync1_reg <= 1'b1;
         sync2_reg <= 1'b1;
      end else begin
         sync1_reg <= raw;
         sync2_reg <= sync1_reg;
      end
   end

   // Any cycle where the synchronised level agrees with db restarts the window.
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         cnt_reg <= '0;
         db_reg  <= 1'b1;
      end else if (sync2_reg != db_reg) begin
         if (cnt_reg == LAST_CNT) begin
            db_reg  <= sync2_reg;
            cnt_reg <= '0;
         end else begin
            cnt_reg <= cnt_reg + 1'b1;
         end
      end else begin
         cnt_reg <= '0;
      end
   end

   assign db = db_reg;

endmodule

// File: rtl/quadrature_decoder.sv
// Rotary-encoder front end: debounces A/B and walks the Gray-code detent
// cycle, pulsing inc/dec once per completed detent and err on illegal jumps.
module quadrature_decoder
   import light_pkg::*;
#(
   parameter int CLOCK_FREQ_MHZ = 100,
   parameter int DELAY_IN_US    = 1
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   quadrature_decoder_if.slave  bus
);

   localparam int DEBOUNCE_CYCLES = CLOCK_FREQ_MHZ * DELAY_IN_US;

   logic [1:0] raw;
   logic [1:0] db;

   // Bit 1 carries contact A, bit 0 contact B, so db reads directly as {a,b}.
   assign raw = {bus.a_i, bus.b_i};

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_contact
         contact_debouncer #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
         ) u_contact (
            .clk_i (clk_i),
            .rst_i (rst_i),
            .raw   (raw[gi]),
            .db    (db[gi])
         );
      end
   endgenerate

   state_t state_reg;
   state_t state_next;
   logic   inc_reg;
   logic   inc_next;
   logic   dec_reg;
   logic   dec_next;
   logic   err_reg;
   logic   err_next;

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         state_reg <= S_IDLE;
         inc_reg   <= 1'b0;
         dec_reg   <= 1'b0;
         err_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         inc_reg   <= inc_next;
         dec_reg   <= dec_next;
         err_reg   <= err_next;
      end
   end

   // Any pair not listed for a state is the unchanged pair, which holds.
   always_comb begin
      state_next = state_reg;
      inc_next   = 1'b0;
      dec_next   = 1'b0;
      err_next   = 1'b0;
      case (state_reg)
         S_IDLE: begin
            case (db)
               2'b01:   state_next = S_R1;
               2'b10:   state_next = S_L1;
               2'b00:   begin state_next = S_WAIT; err_next = 1'b1; end
               default: ;
            endcase
         end
         S_R1: begin
            case (db)
               2'b00:   state_next = S_R2;
               2'b11:   state_next = S_IDLE;
               2'b10:   begin state_next = S_WAIT; err_next = 1'b1; end
               default: ;
            endcase
         end
         S_R2: begin
            case (db)
               2'b10:   state_next = S_R3;
               2'b01:   state_next = S_R1;
               2'b11:   begin state_next = S_WAIT; err_next = 1'b1; end
               default: ;
            endcase
         end
         S_R3: begin
            case (db)
               2'b11:   begin state_next = S_IDLE; inc_next = 1'b1; end
               2'b00:   state_next = S_R2;
               2'b01:   begin state_next = S_WAIT; err_next = 1'b1; end
               default: ;
            endcase
         end
         S_L1: begin
            case (db)
               2'b00:   state_next = S_L2;
               2'b11:   state_next = S_IDLE;
               2'b01:   begin state_next = S_WAIT; err_next = 1'b1; end
               default: ;
            endcase
         end
         S_L2: begin
            case (db)
               2'b01:   state_next = S_L3;
               2'b10:   state_next = S_L1;
               2'b11:   begin state_next = S_WAIT; err_next = 1'b1; end
               default: ;
            endcase
         end
         S_L3: begin
            case (db)
               2'b11:   begin state_next = S_IDLE; dec_next = 1'b1; end
               2'b00:   state_next = S_L2;
               2'b10:   begin state_next = S_WAIT; err_next = 1'b1; end
               default: ;
            endcase
         end
         S_WAIT: begin
            if (db == IDLE_LEVEL) begin
               state_next = S_IDLE;
            end
         end
         default: state_next = S_IDLE;
      endcase
   end

   assign bus.a_db_o = db[1];
   assign bus.b_db_o = db[0];
   assign bus.inc_o  = inc_reg;
   assign bus.dec_o  = dec_reg;
   assign bus.err_o  = err_reg;

endmodule

// File: tb/tb_quadrature_decoder.sv
// Directed bench for quadrature_decoder with a position-counting reference
// model checked every cycle, plus hand-computed strobe counts and latency.
module tb_quadrature_decoder;

   localparam int D = 100;

   logic clk = 1'b0;
   logic rst_i = 1'b0;

   quadrature_decoder_if bus ();

   quadrature_decoder #(
      .CLOCK_FREQ_MHZ(100),
      .DELAY_IN_US   (1)
   ) dut (
      .clk_i (clk),
      .rst_i (rst_i),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;

   task automatic check(input string name, input logic act, input logic exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s at cycle %0d: got %b, required %b", name, cyc, act, exp);
      end
   endtask

   task automatic check_int(input string name, input int act, input int lo, input int hi);
      vectors++;
      if (act < lo || act > hi) begin
         miscompares++;
         $display("FAIL %s at cycle %0d: got %0d, required %0d..%0d", name, cyc, act, lo, hi);
      end
   endtask

   // Reference model: contacts settle after D steady samples seen 2 cycles late;
   // the decoder is a signed Gray-code position that must reach +/-4 at 11.
   function automatic int gray_pos(input logic [1:0] p);
      case (p)
         2'b11:   return 0;
         2'b01:   return 1;
         2'b00:   return 2;
         default: return 3;
      endcase
   endfunction

   bit         model_valid = 0;
   logic [1:0] seen_q [$];
   logic [1:0] db_m;
   logic [1:0] last_m;
   int         run_m [2];
   int         disp;
   bit         wait_m;
   bit         exp_inc, exp_dec, exp_err;

   always @(posedge clk) begin
      logic [1:0] seen;
      logic [1:0] db_nx;
      int         d;
      cyc++;
      if (!rst_i) begin
         model_valid = 1;
         seen_q = '{2'b11, 2'b11};
         db_m = 2'b11; last_m = 2'b11;
         run_m[0] = 0; run_m[1] = 0;
         disp = 0; wait_m = 0;
         exp_inc = 0; exp_dec = 0; exp_err = 0;
      end else if (model_valid) begin
         exp_inc = 0; exp_dec = 0; exp_err = 0;
         d = (gray_pos(db_m) - gray_pos(last_m) + 4) % 4;
         if (wait_m) begin
            if (db_m == 2'b11) begin wait_m = 0; disp = 0; end
         end else if (d == 2) begin
            exp_err = 1; wait_m = 1;
         end else begin
            if (d == 1) disp++;
            else if (d == 3) disp--;
            if (db_m == 2'b11) begin
               exp_inc = (disp == 4);
               exp_dec = (disp == -4);
               disp = 0;
            end
         end
         last_m = db_m;
         seen = seen_q.pop_front();
         seen_q.push_back({bus.a_i, bus.b_i});
         db_nx = db_m;
         for (int ch = 0; ch < 2; ch++) begin
            if (seen[ch] != db_m[ch]) begin
               run_m[ch]++;
               if (run_m[ch] == D) begin db_nx[ch] = seen[ch]; run_m[ch] = 0; end
            end else begin
               run_m[ch] = 0;
            end
         end
         db_m = db_nx;
      end
   end

   int inc_cnt = 0, dec_cnt = 0, err_cnt = 0;
   int inc_rise = -1;

   always @(negedge clk) begin
      if (model_valid) begin
         check("a_db", bus.a_db_o, db_m[1]);
         check("b_db", bus.b_db_o, db_m[0]);
         check("inc", bus.inc_o, exp_inc);
         check("dec", bus.dec_o, exp_dec);
         check("err", bus.err_o, exp_err);
      end
      if (bus.inc_o === 1'b1) begin inc_cnt++; inc_rise = cyc; end
      if (bus.dec_o === 1'b1) dec_cnt++;
      if (bus.err_o === 1'b1) err_cnt++;
   end

   int last_a = 0, last_b = 0;

   task automatic set_pin(input int ch, input logic v);
      if (ch == 1) begin
         if (bus.a_i !== v) last_a = cyc;
         bus.a_i = v;
      end else begin
         if (bus.b_i !== v) last_b = cyc;
         bus.b_i = v;
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic bounce(input int ch, input logic lvl);
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         set_pin(ch, logic'($urandom_range(0, 1)));
      end
      @(negedge clk);
      set_pin(ch, lvl);
   endtask

   // lead = 1 turns clockwise (A first), lead = 0 counter-clockwise.
   task automatic turn(input int lead, input string tag, input int exp_i, input int exp_d);
      int i0, d0, e0, t_last;
      int lag;
      i0 = inc_cnt; d0 = dec_cnt; e0 = err_cnt;
      lag = 1 - lead;
      inc_rise = -1;
      bounce(lead, 1'b0); idle(300);
      bounce(lag, 1'b0);  idle(500);
      bounce(lead, 1'b1); idle(300);
      bounce(lag, 1'b1);
      t_last = (lag == 1) ? last_a : last_b;
      idle(400);
      check_int({tag, "_inc_count"}, inc_cnt - i0, exp_i, exp_i);
      check_int({tag, "_dec_count"}, dec_cnt - d0, exp_d, exp_d);
      check_int({tag, "_err_count"}, err_cnt - e0, 0, 0);
      if (exp_i == 1) check_int({tag, "_inc_latency"}, inc_rise - t_last, 102, 104);
   endtask

   initial begin
      int i0, d0, e0;
      bus.a_i = 1'b1;
      bus.b_i = 1'b1;
      rst_i = 1'b0;
      idle(3);
      check("reset_a_db", bus.a_db_o, 1'b1);
      check("reset_b_db", bus.b_db_o, 1'b1);
      check("reset_inc", bus.inc_o, 1'b0);
      check("reset_err", bus.err_o, 1'b0);
      rst_i = 1'b1;

      idle(2000);
      check_int("idle_strobes", inc_cnt + dec_cnt + err_cnt, 0, 0);
      check("idle_a_db", bus.a_db_o, 1'b1);

      turn(1, "cw", 1, 0);
      turn(0, "ccw", 0, 1);

      i0 = inc_cnt; d0 = dec_cnt; e0 = err_cnt;
      for (int g = 0; g < 10; g++) begin
         @(negedge clk); set_pin(1, 1'b0);
         idle(50);       set_pin(1, 1'b1);
         idle(150);
      end
      check("glitch_a_db", bus.a_db_o, 1'b1);
      check_int("glitch_strobes", (inc_cnt - i0) + (dec_cnt - d0) + (err_cnt - e0), 0, 0);

      i0 = inc_cnt; d0 = dec_cnt; e0 = err_cnt;
      bounce(1, 1'b0); idle(400);
      bounce(1, 1'b1); idle(400);
      check_int("partial_strobes", (inc_cnt - i0) + (dec_cnt - d0) + (err_cnt - e0), 0, 0);
      turn(1, "cw_after_partial", 1, 0);

      i0 = inc_cnt; d0 = dec_cnt; e0 = err_cnt;
      @(negedge clk); set_pin(1, 1'b0); set_pin(0, 1'b0);
      idle(300);
      check_int("jump_err_count", err_cnt - e0, 1, 1);
      @(negedge clk); set_pin(1, 1'b1); set_pin(0, 1'b1);
      idle(300);
      check_int("jump_err_after_return", err_cnt - e0, 1, 1);
      check_int("jump_incdec", (inc_cnt - i0) + (dec_cnt - d0), 0, 0);
      turn(1, "cw_after_jump", 1, 0);

      bounce(1, 1'b0); idle(300);
      bounce(0, 1'b0); idle(300);
      @(negedge clk);
      set_pin(1, 1'b1); set_pin(0, 1'b1);
      rst_i = 1'b0;
      @(negedge clk);
      check("midreset_a_db", bus.a_db_o, 1'b1);
      check("midreset_b_db", bus.b_db_o, 1'b1);
      check("midreset_inc", bus.inc_o, 1'b0);
      check("midreset_dec", bus.dec_o, 1'b0);
      check("midreset_err", bus.err_o, 1'b0);
      rst_i = 1'b1;
      idle(400);
      turn(1, "cw_after_reset", 1, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/quadrature_decoder.md
Name: quadrature_decoder

Overview:
- Front-end stage of light_manager, sitting between the raw rotary-encoder GPIO pins (a_i, b_i) and the brightness/PWM logic.
- Synchronises and debounces both contacts.
- Tracks the full Gray-code detent cycle and emits one single-cycle inc or dec strobe per completed detent.
- Partial, reversed or illegal rotations produce no strobe.

Parameters:
- CLOCK_FREQ_MHZ, 100, clock frequency in MHz (1..655).
- DELAY_IN_US, 1, bounce window in us; DEBOUNCE_CYCLES = CLOCK_FREQ_MHZ*DELAY_IN_US, which must satisfy 1..65535.

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  synchronous, active-low reset.
- a_i  in  1  raw encoder contact A, asynchronous, idle high.
- b_i  in  1  raw encoder contact B, asynchronous, idle high.
- a_db_o  out  1  debounced A level.
- b_db_o  out  1  debounced B level.
- inc_o  out  1  one-cycle strobe: clockwise detent completed.
- dec_o  out  1  one-cycle strobe: counter-clockwise detent completed.
- err_o  out  1  one-cycle strobe: illegal two-bit jump detected.

Behaviour:
- Reset (rst_i==0 at posedge clk_i):
  - Synchroniser flops = 1, a_db_o = b_db_o = 1.
  - Debounce counters = 0, FSM = IDLE.
  - inc_o = dec_o = err_o = 0.
- Synchroniser: 2-flop chain per input; raw-to-sync latency is 2 cycles.
- Debounce, per channel:
  - 16-bit counter; while sync != db, counter increments; any cycle with sync == db clears the counter.
  - When the counter reaches DEBOUNCE_CYCLES-1 with sync != db, db takes sync on the next edge and the counter clears.
  - Net latency from the last raw bounce to the db change is 2 + DEBOUNCE_CYCLES cycles.
  - A pulse shorter than DEBOUNCE_CYCLES never propagates.
- Debounced pair is written {a,b}. Clockwise sequence is 11->01->00->10->11; counter-clockwise is 11->10->00->01->11.
- FSM states: IDLE, R1, R2, R3, L1, L2, L3, WAIT. State and outputs are registered, and the FSM evaluates db every cycle.
  - IDLE: 01->R1; 10->L1; 00->WAIT + err.
  - R1: 00->R2; 11->IDLE (abandoned, no strobe); 10->WAIT + err.
  - R2: 10->R3; 01->R1 (reversal); 11->WAIT + err.
  - R3: 11->IDLE + inc; 00->R2; 01->WAIT + err.
  - L1: 00->L2; 11->IDLE; 01->WAIT + err.
  - L2: 01->L3; 10->L1; 11->WAIT + err.
  - L3: 11->IDLE + dec; 00->L2; 10->WAIT + err.
  - WAIT: stays until db==11, then goes to IDLE with no strobe. No err while already in WAIT.
  - Any state: an unchanged db pair holds the state.
- Strobes are asserted for exactly one cycle, on the cycle after db returns to 11. inc_o and dec_o are never high together.
- Reset mid-rotation: reset returns to IDLE with db=11. The next rotation is decoded only once db has first settled at 11 (IDLE waits for a single-bit change).
- Both channels are debounced independently; simultaneous db changes are possible and are handled by the illegal-jump rows.

Decomposition:
- Package light_pkg holds:
  - FSM state localparams (3-bit encoding: IDLE=0, R1..R3=1..3, L1..L3=4..6, WAIT=7).
  - DEBOUNCE_CNT_W = 16.
  - Idle level constant 2'b11.
- One sub-module, contact_debouncer (synchroniser + counter, parameter DEBOUNCE_CYCLES), instantiated once per channel. The FSM stays in quadrature_decoder.

Test Plan (100 MHz, DELAY_IN_US=1, DEBOUNCE_CYCLES=100):
- Reset then idle 2000 cycles with a_i=b_i=1 -> a_db_o=b_db_o=1, no strobes.
- Clockwise detent:
  - Stimulus: A bounces randomly for 100 cycles, then is held 0; B does the same 3 us later; A and B return high through similar bounces 5 us after settling.
  - Response: exactly one inc_o pulse, dec_o=0, err_o=0. inc_o rises 103 cycles (±1) after the last B bounce.
- Counter-clockwise detent, same stimulus with B leading -> exactly one dec_o pulse, no inc_o.
- Glitches on A of 50 cycles, repeated 10 times -> a_db_o stays 1, FSM stays IDLE, no strobes.
- Partial turn: A drops and settles, then returns high without B moving -> no strobes, FSM back in IDLE.
- Illegal jump: A and B driven 11->00 on the same cycle -> err_o pulses once, no inc/dec. After a return to 11, a following clockwise turn yields one inc_o.
- Reset mid-rotation: rst_i=0 for 1 cycle while in R2 -> outputs reset next edge. A subsequent full CW turn started after inputs are at 11 yields one inc_o.
